// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, registered one-cycle strobes.
// Define UART_RX_PARITY_EN to add a parity bit after data bit 7 (PARITY_ODD selects the sense).
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic [1:0] state_out
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'((CLKS_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
  // Index 8 is the parity bit; it shares the DATA state.
  localparam int unsigned IdxW = 4;
  localparam logic [IdxW-1:0] LastIdx = 4'd8;
`else
  localparam int unsigned IdxW = 3;
  localparam logic [IdxW-1:0] LastIdx = 3'd7;
`endif

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic            rx_meta_q, rx_s_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            perr_q, perr_d;
  logic            err_hold_q, err_hold_d;
  logic            tick_bit, tick_half;
  logic            par_mismatch;

  assign tick_bit  = (cnt_q == CntMax);
  assign tick_half = (cnt_q == CntHalf);

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  assign par_mismatch = (par_q != (^shift_q ^ PARITY_ODD));
`else
  assign par_mismatch = 1'b0;
`endif

  // Synchroniser for the asynchronous pin; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (tick_half) state_d = rx_s_q ? StIdle : StData;
      end
      StData: begin
        if (tick_bit && (bit_idx_q == LastIdx)) state_d = StStop;
      end
      StStop: begin
        if (err_hold_q) begin
          if (rx_s_q) state_d = StIdle;
        end else if (tick_bit && rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
    err_hold_d = err_hold_q;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d      = '0;
        bit_idx_d  = '0;
        err_hold_d = 1'b0;
      end
      StStart: begin
        bit_idx_d = '0;
        if (tick_half) cnt_d = '0;
      end
      StData: begin
        if (tick_bit) begin
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx_q == LastIdx) par_d = rx_s_q;
          else                      shift_d = {rx_s_q, shift_q[7:1]};
`else
          shift_d = {rx_s_q, shift_q[7:1]};
`endif
        end
      end
      StStop: begin
        if (err_hold_q) begin
          // Counter frozen while a break holds the line low.
          cnt_d = cnt_q;
        end else if (tick_bit) begin
          if (!rx_s_q) begin
            ferr_d     = 1'b1;
            err_hold_d = 1'b1;
            cnt_d      = cnt_q;
          end else if (par_mismatch) begin
            perr_d = 1'b1;
            cnt_d  = '0;
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
            cnt_d   = '0;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      err_hold_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      err_hold_q <= err_hold_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=8: vector table plus multi-cycle corner sequences.
module tb_uart_rx;

  localparam int unsigned Bit = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic [1:0] state_out;

  int checks = 0;
  int failures = 0;

  int n_valid = 0, n_ferr = 0, n_perr = 0, n_long = 0, n_multi = 0, cyc = 0;
  int t_valid[$];
  logic [7:0] d_hist[$];
  logic prev_v = 1'b0, prev_f = 1'b0, prev_p = 1'b0;

  uart_rx #(.CLKS_PER_BIT(Bit), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (data_valid === 1'b1) begin
      n_valid = n_valid + 1;
      t_valid.push_back(cyc);
      d_hist.push_back(data_out);
    end
    if (frame_err === 1'b1) n_ferr = n_ferr + 1;
    if (parity_err === 1'b1) n_perr = n_perr + 1;
    if ((data_valid === 1'b1 && prev_v) || (frame_err === 1'b1 && prev_f) ||
        (parity_err === 1'b1 && prev_p)) n_long = n_long + 1;
    if ((int'(data_valid === 1'b1) + int'(frame_err === 1'b1) + int'(parity_err === 1'b1)) > 1)
      n_multi = n_multi + 1;
    prev_v = (data_valid === 1'b1);
    prev_f = (frame_err === 1'b1);
    prev_p = (parity_err === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (Bit) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, f0, p0;
    logic [7:0] held;

    vecs[0] = '{data: 8'hA5, par: 1'b0, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'hA5};
    vecs[1] = '{data: 8'h00, par: 1'b0, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h00};
    vecs[2] = '{data: 8'hFF, par: 1'b0, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'hFF};
    vecs[3] = '{data: 8'h55, par: 1'b0, stop: 1'b0, exp_valid: 0, exp_ferr: 1, exp_data: 8'hFF};
    vecs[4] = '{data: 8'h07, par: 1'b1, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h07};
    vecs[5] = '{data: 8'h81, par: 1'b0, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h81};

    // Reset with rx low.
    rst = 1'b1;
    rx  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_state", 32'(state_out), 32'h0);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_state", 32'(state_out), 32'h0);
    check("post_rst_strobes", 32'(n_valid + n_ferr + n_perr), 32'h0);

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      v0 = n_valid; f0 = n_ferr; p0 = n_perr;
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      rx = 1'b1;
      repeat (24) @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ferr", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_perr", i), 32'(n_perr - p0), 32'h0);
      check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_state", i), 32'(state_out), 32'h0);
    end

    // Back-to-back A5, 3C with no idle between frames.
    t_valid.delete();
    d_hist.delete();
    send_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    check("b2b_count", 32'(d_hist.size()), 32'd2);
    if (d_hist.size() == 2 && t_valid.size() == 2) begin
      check("b2b_first", 32'(d_hist[0]), 32'hA5);
      check("b2b_second", 32'(d_hist[1]), 32'h3C);
`ifdef UART_RX_PARITY_EN
      check("b2b_gap", 32'(t_valid[1] - t_valid[0]), 32'd88);
`else
      check("b2b_gap", 32'(t_valid[1] - t_valid[0]), 32'd80);
`endif
    end

    // Start-bit glitch: rx low 3 cycles.
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    held = data_out;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_in_start", 32'(state_out), 32'h1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_idle", 32'(state_out), 32'h0);
    check("glitch_no_strobe", 32'(n_valid + n_ferr + n_perr - v0 - f0 - p0), 32'h0);
    check("glitch_data", 32'(data_out), 32'(held));

    // Bad stop bit followed by a 50-cycle break.
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h55, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    check("break_ferr_once", 32'(n_ferr - f0), 32'd1);
    check("break_state_stop", 32'(state_out), 32'h3);
    check("break_no_valid", 32'(n_valid - v0), 32'h0);
    check("break_data", 32'(data_out), 32'(held));
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("break_release_idle", 32'(state_out), 32'h0);
    check("break_ferr_after", 32'(n_ferr - f0), 32'd1);

    // Reset during data bit 4 of FF, then a clean 12.
    v0 = n_valid; f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("abort_no_strobe", 32'(n_valid + n_ferr - v0 - f0), 32'h0);
    check("abort_data_cleared", 32'(data_out), 32'h00);
    send_frame(8'h12, 1'b0, 1'b1);
    repeat (24) @(negedge clk);
    check("abort_next_valid", 32'(n_valid - v0), 32'd1);
    check("abort_next_data", 32'(data_out), 32'h12);

`ifdef UART_RX_PARITY_EN
    p0 = n_perr; v0 = n_valid;
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (24) @(negedge clk);
    check("par_good_valid", 32'(n_valid - v0), 32'd1);
    check("par_good_data", 32'(data_out), 32'h07);
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (24) @(negedge clk);
    check("par_bad_perr", 32'(n_perr - p0), 32'd1);
    check("par_bad_no_valid", 32'(n_valid - v0), 32'd1);
    check("par_bad_data", 32'(data_out), 32'h07);
`endif

    check("strobe_width", 32'(n_long), 32'h0);
    check("strobe_exclusive", 32'(n_multi), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
